// File: rtl/down_counter_sequencer_if.sv
// rtl/down_counter_sequencer_if.sv - control/status bundle for the down counter sequencer
interface down_counter_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             pause;
    logic             abort;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    // Controller side: issues commands, observes the count.
    modport master (
        output start, load_val, pause, abort, auto_reload,
        input  q, q_bar, busy, done, state
    );

    // Sequencer side: receives commands, reports the count.
    modport slave (
        input  start, load_val, pause, abort, auto_reload,
        output q, q_bar, busy, done, state
    );
endinterface

// File: rtl/down_counter_sequencer.sv
// rtl/down_counter_sequencer.sv - prescaled down counter with pause, abort and auto-reload
module down_counter_sequencer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    down_counter_sequencer_if.slave  bus
);
    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PC_LAST  = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             done_q, done_d;

    // State and datapath registers; reset parks the counter at all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            q_q      <= ALL_ONES;
            reload_q <= '0;
            pcnt_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            pcnt_q   <= pcnt_d;
            done_q   <= done_d;
        end
    end

    // Next state: abort beats pause beats tick. Leaving PAUSED takes a
    // normal run step in the same cycle, so only pause-high cycles stall.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        pcnt_d   = pcnt_q;
        done_d   = 1'b0;
        case (state_q)
            S_RUN, S_PAUSED: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    q_d     = ALL_ONES;
                    pcnt_d  = '0;
                end else if (bus.pause) begin
                    state_d = S_PAUSED;
                end else begin
                    state_d = S_RUN;
                    if (pcnt_q == PC_LAST) begin
                        pcnt_d = '0;
                        if (q_q != '0) begin
                            q_d = q_q - 1'b1;
                        end else begin
                            done_d = 1'b1;
                            if (bus.auto_reload) begin
                                q_d = reload_q;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                // IDLE (and the unused encoding) only listens for start.
                if (bus.start) begin
                    state_d  = S_RUN;
                    q_d      = bus.load_val;
                    reload_d = bus.load_val;
                    pcnt_d   = '0;
                end
            end
        endcase
    end

    assign bus.q     = q_q;
    assign bus.q_bar = ~q_q;
    assign bus.busy  = (state_q == S_RUN) || (state_q == S_PAUSED);
    assign bus.done  = done_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_down_counter_sequencer.sv
// tb/tb_down_counter_sequencer.sv - bench for down_counter_sequencer
module tb_down_counter_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       start, pause, abort, auto_reload;
    logic [3:0] load_val;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    down_counter_sequencer_if #(.WIDTH(4)) if0 ();
    down_counter_sequencer_if #(.WIDTH(4)) if1 ();

    assign if0.start = start;  assign if0.load_val = load_val; assign if0.pause = pause;
    assign if0.abort = abort;  assign if0.auto_reload = auto_reload;
    assign if1.start = start;  assign if1.load_val = load_val; assign if1.pause = pause;
    assign if1.abort = abort;  assign if1.auto_reload = auto_reload;

    down_counter_sequencer #(.WIDTH(4), .PRESCALE(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    down_counter_sequencer #(.WIDTH(4), .PRESCALE(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    logic [3:0] d_q[2];
    logic [3:0] d_qb[2];
    logic       d_busy[2];
    logic       d_done[2];
    logic [1:0] d_st[2];
    assign d_q[0] = if0.q;  assign d_qb[0] = if0.q_bar;  assign d_busy[0] = if0.busy;
    assign d_done[0] = if0.done;  assign d_st[0] = if0.state;
    assign d_q[1] = if1.q;  assign d_qb[1] = if1.q_bar;  assign d_busy[1] = if1.busy;
    assign d_done[1] = if1.done;  assign d_st[1] = if1.state;

    // Reference model: a count is "elapsed active cycles" since load; the
    // visible value is reload - elapsed/P and the terminal tick is reached
    // after (reload+1)*P active cycles.
    int m_mode[2];   // 0 idle, 1 run, 2 paused
    int m_el[2];
    int m_rel[2];
    int m_idle_q[2];
    bit m_done[2];
    int m_p;

    function automatic logic [3:0] model_q(int d);
        if (m_mode[d] == 0) return 4'(m_idle_q[d]);
        return 4'(m_rel[d] - m_el[d] / ((d == 0) ? 1 : 3));
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_p = (d == 0) ? 1 : 3;
            m_done[d] = 1'b0;
            if (rst) begin
                m_mode[d] = 0; m_idle_q[d] = 15; m_rel[d] = 0; m_el[d] = 0;
            end else if (m_mode[d] == 0) begin
                if (start) begin
                    m_mode[d] = 1; m_rel[d] = int'(load_val); m_el[d] = 0;
                end
            end else if (abort) begin
                m_mode[d] = 0; m_idle_q[d] = 15;
            end else if (pause) begin
                m_mode[d] = 2;
            end else begin
                m_mode[d] = 1;
                m_el[d]++;
                if (m_el[d] == (m_rel[d] + 1) * m_p) begin
                    m_done[d] = 1'b1;
                    if (auto_reload) m_el[d] = 0;
                    else begin m_mode[d] = 0; m_idle_q[d] = 0; end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; auto_reload = 1'b0; load_val = '0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; load_val = 4'd9; pause = 1'b0; abort = 1'b0; auto_reload = 1'b1;
        cyc(); cyc();
        for (int d = 0; d < 2; d++) begin
            n_tests++; if (d_q[d] !== 4'b1111) begin n_fail++; $display("FAIL reset_q dut%0d got %h want f", d, d_q[d]); end
            n_tests++; if (d_qb[d] !== 4'b0000) begin n_fail++; $display("FAIL reset_qbar dut%0d got %h want 0", d, d_qb[d]); end
            n_tests++; if (d_busy[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d got %b want 0", d, d_busy[d]); end
            n_tests++; if (d_done[d] !== 1'b0) begin n_fail++; $display("FAIL reset_done dut%0d got %b want 0", d, d_done[d]); end
            n_tests++; if (d_st[d] !== 2'd0) begin n_fail++; $display("FAIL reset_state dut%0d got %0d want 0", d, d_st[d]); end
        end
        rst = 1'b0; start = 1'b0; auto_reload = 1'b0;
    endtask

    task automatic test_count_down();
        do_reset();
        load_val = 4'd5; start = 1'b1;
        cyc();
        start = 1'b0;
        n_tests++; if (d_q[0] !== 4'd5 || d_busy[0] !== 1'b1) begin n_fail++; $display("FAIL cd_load got q=%0d busy=%b want q=5 busy=1", d_q[0], d_busy[0]); end
        for (int i = 1; i <= 7; i++) begin
            cyc();
            n_tests++; if (d_q[0] !== 4'((i <= 5) ? 5 - i : 0)) begin n_fail++; $display("FAIL cd_q edge%0d got %0d want %0d", i, d_q[0], (i <= 5) ? 5 - i : 0); end
            n_tests++; if (d_done[0] !== (i == 6)) begin n_fail++; $display("FAIL cd_done edge%0d got %b want %b", i, d_done[0], i == 6); end
            n_tests++; if (d_busy[0] !== (i < 6)) begin n_fail++; $display("FAIL cd_busy edge%0d got %b want %b", i, d_busy[0], i < 6); end
        end
    endtask

    task automatic test_start_while_busy();
        do_reset();
        load_val = 4'd5; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        load_val = 4'd12; start = 1'b1;
        cyc();
        start = 1'b0;
        n_tests++; if (d_q[0] !== 4'd3 || d_busy[0] !== 1'b1) begin n_fail++; $display("FAIL busy_start got q=%0d busy=%b want q=3 busy=1", d_q[0], d_busy[0]); end
    endtask

    task automatic test_auto_reload();
        do_reset();
        load_val = 4'd2; start = 1'b1; auto_reload = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            cyc();
            n_tests++; if (d_q[0] !== 4'(2 - (i % 3))) begin n_fail++; $display("FAIL ar_q edge%0d got %0d want %0d", i, d_q[0], 2 - (i % 3)); end
            n_tests++; if (d_done[0] !== (i % 3 == 0)) begin n_fail++; $display("FAIL ar_done edge%0d got %b want %b", i, d_done[0], i % 3 == 0); end
            n_tests++; if (d_busy[0] !== 1'b1) begin n_fail++; $display("FAIL ar_busy edge%0d got %b want 1", i, d_busy[0]); end
        end
        auto_reload = 1'b0;
        cyc(); cyc(); cyc();
        n_tests++; if (d_done[0] !== 1'b1 || d_busy[0] !== 1'b0 || d_q[0] !== 4'd0 || d_st[0] !== 2'd0)
            begin n_fail++; $display("FAIL ar_stop got done=%b busy=%b q=%0d st=%0d want 1 0 0 0", d_done[0], d_busy[0], d_q[0], d_st[0]); end
    endtask

    task automatic test_pause();
        int n;
        do_reset();
        load_val = 4'd7; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        n_tests++; if (d_q[0] !== 4'd3) begin n_fail++; $display("FAIL pz_pre got %0d want 3", d_q[0]); end
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_tests++; if (d_q[0] !== 4'd3 || d_st[0] !== 2'd2) begin n_fail++; $display("FAIL pz_hold cyc%0d got q=%0d st=%0d want q=3 st=2", i, d_q[0], d_st[0]); end
        end
        pause = 1'b0;
        cyc();
        n_tests++; if (d_q[0] !== 4'd2 || d_st[0] !== 2'd1) begin n_fail++; $display("FAIL pz_release got q=%0d st=%0d want q=2 st=1", d_q[0], d_st[0]); end
        n = 9;
        while (d_done[0] !== 1'b1 && n < 40) begin cyc(); n++; end
        n_tests++; if (n != 12) begin n_fail++; $display("FAIL pz_done_edge got %0d want 12", n); end
        // abort while paused
        do_reset();
        load_val = 4'd7; start = 1'b1;
        cyc();
        start = 1'b0; cyc(); pause = 1'b1; cyc(); cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0; pause = 1'b0;
        n_tests++; if (d_q[0] !== 4'b1111 || d_busy[0] !== 1'b0 || d_st[0] !== 2'd0 || d_done[0] !== 1'b0)
            begin n_fail++; $display("FAIL pz_abort got q=%h busy=%b st=%0d done=%b want f 0 0 0", d_q[0], d_busy[0], d_st[0], d_done[0]); end
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_tests++; if (d_done[0] !== 1'b0 || d_q[0] !== 4'b1111) begin n_fail++; $display("FAIL pz_after_abort cyc%0d got done=%b q=%h want 0 f", i, d_done[0], d_q[0]); end
        end
    endtask

    task automatic test_abort_terminal();
        do_reset();
        load_val = 4'd6; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        n_tests++; if (d_q[0] !== 4'd0 || d_busy[0] !== 1'b1) begin n_fail++; $display("FAIL at_pre got q=%0d busy=%b want 0 1", d_q[0], d_busy[0]); end
        abort = 1'b1; start = 1'b1; load_val = 4'd4;
        cyc();
        abort = 1'b0; start = 1'b0;
        n_tests++; if (d_q[0] !== 4'b1111 || d_st[0] !== 2'd0 || d_done[0] !== 1'b0 || d_busy[0] !== 1'b0)
            begin n_fail++; $display("FAIL at_abort got q=%h st=%0d done=%b busy=%b want f 0 0 0", d_q[0], d_st[0], d_done[0], d_busy[0]); end
        cyc();
        n_tests++; if (d_st[0] !== 2'd0 || d_q[0] !== 4'b1111 || d_done[0] !== 1'b0) begin n_fail++; $display("FAIL at_no_start got st=%0d q=%h done=%b want 0 f 0", d_st[0], d_q[0], d_done[0]); end
    endtask

    task automatic test_prescale();
        do_reset();
        load_val = 4'd1; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            cyc();
            n_tests++; if (d_q[1] !== 4'((i < 3) ? 1 : 0)) begin n_fail++; $display("FAIL ps_q edge%0d got %0d want %0d", i, d_q[1], (i < 3) ? 1 : 0); end
            n_tests++; if (d_done[1] !== (i == 6)) begin n_fail++; $display("FAIL ps_done edge%0d got %b want %b", i, d_done[1], i == 6); end
        end
        do_reset();
        load_val = 4'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            n_tests++; if (d_done[1] !== (i == 3)) begin n_fail++; $display("FAIL ps0_done edge%0d got %b want %b", i, d_done[1], i == 3); end
        end
    endtask

    task automatic test_random();
        logic [3:0] eq;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rst         = ($urandom_range(0, 149) == 0);
            start       = ($urandom_range(0, 3) == 0);
            load_val    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            pause       = ($urandom_range(0, 5) == 0);
            abort       = ($urandom_range(0, 39) == 0);
            auto_reload = 1'($urandom_range(0, 1));
            cyc();
            for (int d = 0; d < 2; d++) begin
                eq = model_q(d);
                n_tests++; if (d_q[d] !== eq) begin n_fail++; $display("FAIL rnd_q dut%0d cyc%0d got %0d want %0d", d, c, d_q[d], eq); end
                n_tests++; if (d_qb[d] !== ~eq) begin n_fail++; $display("FAIL rnd_qbar dut%0d cyc%0d got %h want %h", d, c, d_qb[d], ~eq); end
                n_tests++; if (d_done[d] !== m_done[d]) begin n_fail++; $display("FAIL rnd_done dut%0d cyc%0d got %b want %b", d, c, d_done[d], m_done[d]); end
                n_tests++; if (d_busy[d] !== (m_mode[d] != 0)) begin n_fail++; $display("FAIL rnd_busy dut%0d cyc%0d got %b want %b", d, c, d_busy[d], m_mode[d] != 0); end
                n_tests++; if (d_st[d] !== 2'(m_mode[d])) begin n_fail++; $display("FAIL rnd_state dut%0d cyc%0d got %0d want %0d", d, c, d_st[d], m_mode[d]); end
            end
        end
        rst = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; auto_reload = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; auto_reload = 1'b0; load_val = '0;
        test_reset();
        test_count_down();
        test_start_while_busy();
        test_auto_reload();
        test_pause();
        test_abort_terminal();
        test_prescale();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/down_counter_sequencer.md
Name: down_counter_sequencer

Overview:
Controller that sequences a WIDTH-bit down counter for timed operations. A start command loads a value, and the block counts down at a prescaled rate. Count can be paused or aborted. A one-cycle done pulse fires at terminal count, with optional auto-reload for periodic operation. Other blocks use it as the timed-interval source in place of a free-running ripple down counter.

Parameters:
WIDTH, 4, counter width in bits (>=2)
PRESCALE, 1, clk cycles per decrement tick (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  begin a count; sampled only in IDLE
load_val  input  WIDTH  start value, captured on accepted start
pause  input  1  level; holds count while high (RUN/PAUSED)
abort  input  1  cancel count; returns to IDLE
auto_reload  input  1  sampled at terminal tick; 1 = reload and continue
q  output  WIDTH  current count (registered)
q_bar  output  WIDTH  bitwise ~q at all times
busy  output  1  high in RUN or PAUSED
done  output  1  one-cycle pulse at terminal tick
state  output  2  IDLE=0, RUN=1, PAUSED=2 (3 unused; decode as IDLE)

Behaviour:
- Everything is synchronous to the rising edge of clk; there are no asynchronous paths.
- Reset (rst=1 at an edge) sets:
  - state=IDLE, q=all ones, q_bar=0, busy=0, done=0.
  - Internal reload_reg=0 and prescale counter pcnt=0.
  - rst overrides all other inputs.
- Priority in RUN/PAUSED: rst > abort > pause > tick.
- IDLE:
  - start=1 → next edge: q=load_val, reload_reg=load_val, pcnt=0, state=RUN, busy=1.
  - Otherwise q holds.
  - pause, abort and auto_reload are ignored in IDLE.
- RUN:
  - pcnt increments each cycle. A tick occurs when pcnt==PRESCALE-1; pcnt then returns to 0. With PRESCALE=1, every RUN cycle is a tick.
  - Tick with q!=0: q=q-1.
  - Tick with q==0 (terminal tick): done=1 for exactly that edge's following cycle, then:
    - auto_reload=1 → q=reload_reg and state stays RUN.
    - auto_reload=0 → state=IDLE, busy=0, q stays 0.
  - Period in auto-reload mode: (reload_reg+1)*PRESCALE cycles per done pulse.
  - pause=1 → state=PAUSED; q and pcnt are frozen and no tick is taken that cycle.
  - abort=1 → state=IDLE, q=all ones, busy=0, pcnt=0. No done pulse, including when abort coincides with a terminal tick.
- PAUSED:
  - pause=0 → RUN. pcnt resumes from its frozen value.
  - abort=1 → IDLE, with the same effects as abort in RUN.
- Latency:
  - start accepted at edge E → first decrement at edge E+PRESCALE.
  - Done is high in the cycle after edge E+(load_val+1)*PRESCALE, excluding pause cycles.
- Boundary conditions:
  - load_val=0 → done at the first tick.
  - load_val=all ones is valid: 2^WIDTH ticks to done.
  - start while busy is ignored and does not restart the count.
  - start and abort in the same RUN cycle: abort wins, start is dropped.
  - start in the same cycle that the FSM enters IDLE is not seen; it must be held or re-issued.
  - auto_reload with reload_reg=0 → done on every tick.
- q never wraps below 0 (no 0 → all-ones underflow).
- done is never high for two consecutive cycles unless a terminal tick recurs (PRESCALE=1 with reload_reg=0).

Test Plan:
1. Reset: assert rst for 2 cycles with start=1 → q=4'b1111, q_bar=4'b0000, busy=0, done=0, state=0.
2. WIDTH=4, PRESCALE=1, start with load_val=5, auto_reload=0 → q reads 5,4,3,2,1,0 on successive cycles. Done is high exactly once, 6 edges after the start edge. busy falls on the same edge, and q stays 0.
3. Start with load_val=2, auto_reload=1 held → q cycles 2,1,0,2,1,0…, done pulses every 3 cycles, busy stays 1. Then drop auto_reload → the next done returns the block to IDLE with q=0.
4. Start with load_val=7; at q=3, hold pause 4 cycles → q=3 and state=2 throughout. Release → q=2 on the next edge, and done timing shifts by 4 cycles. abort during pause → q=4'b1111, busy=0, no done.
5. Start with load_val=6; at q=0 with auto_reload=0, assert abort and start together → q=4'b1111, state=IDLE, done stays 0, and start is not accepted.
6. PRESCALE=3, load_val=1 → q changes only every 3 cycles (1→0 at edge 3); done at edge 6 after start. Separately, load_val=0 → done at edge 3.
